// File: rtl/sdram_avmm_pkg.sv
// Shared constants for the SDRAM Avalon-MM responder: bus widths and FSM states.
package sdram_avmm_pkg;

    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

endpackage

// File: rtl/avmm_rd_pipe.sv
// Fixed-latency read return pipe: valid + data shift line, flushed by sync reset.
// Data stages only load behind a valid bit, so the last stage holds the most
// recently returned word between pulses.
module avmm_rd_pipe
    import sdram_avmm_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic [STAGES-1:0]             vld_pipe_q, vld_pipe_d;
    logic [STAGES-1:0][DATA_W-1:0] data_pipe_q, data_pipe_d;

    // Shift valid every cycle; move data only where a valid word arrives.
    always_comb begin
        vld_pipe_d  = '0;
        data_pipe_d = data_pipe_q;
        vld_pipe_d[0] = in_vld;
        if (in_vld) data_pipe_d[0] = in_data;
        for (int s = 1; s < STAGES; s++) begin
            vld_pipe_d[s] = vld_pipe_q[s-1];
            if (vld_pipe_q[s-1]) data_pipe_d[s] = data_pipe_q[s-1];
        end
    end

    // Pipe registers; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q  <= '0;
            data_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            data_pipe_q <= data_pipe_d;
        end
    end

    assign out_vld  = vld_pipe_q[STAGES-1];
    assign out_data = data_pipe_q[STAGES-1];

endmodule

// File: rtl/sdram_avmm_responder.sv
// Avalon-MM slave standing in for the 16-bit SDRAM port: programmable wait
// states, pipelined in-order reads of fixed latency, byte-lane writes to RAM.
module sdram_avmm_responder
    import sdram_avmm_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int WAIT_STATES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [BE_W-1:0]   byteenable,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] writedata,
    output logic              waitrequest,
    output logic              readdatavalid,
    output logic [DATA_W-1:0] readdata,
    output logic              protocol_err,
    output logic [31:0]       toHexLed
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          perr_q, perr_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    logic              cmd, both_low, full, accept, rd_acc, wr_acc;
    logic [AW-1:0]     widx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              unused_addr;

    assign widx        = address[AW:1];
    assign unused_addr = ^{address[31:AW+1], address[0]};

    assign cmd      = chipselect & (read_n ^ write_n);
    assign both_low = chipselect & ~read_n & ~write_n;
    assign full     = (pend_q == PW'(MAX_PENDING));

    // Handshake FSM. The IDLE cycle counts as the first wait state, so cnt
    // holds the wait cycles still owed after the current one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        perr_d      = perr_q | both_low;
        waitrequest = 1'b0;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd) begin
                    if (WAIT_STATES == 0) begin
                        waitrequest = full;
                        accept      = ~full;
                        if (full) state_d = ST_GRANT;
                    end else begin
                        waitrequest = 1'b1;
                        cnt_d       = CW'(WAIT_STATES - 1);
                        state_d     = (WAIT_STATES == 1) ? ST_GRANT : ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                waitrequest = 1'b1;
                if (!cmd) begin
                    state_d = ST_IDLE;
                    perr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                waitrequest = full;
                if (!cmd) begin
                    state_d = ST_IDLE;
                    perr_d  = 1'b1;
                end else if (!full) begin
                    accept  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_acc = accept & ~read_n & ~reset;
    assign wr_acc = accept & ~write_n & ~reset;

    // Outstanding-read tracking and accepted-command counters.
    always_comb begin
        pend_d = pend_q;
        if (rd_acc && !readdatavalid)      pend_d = pend_q + PW'(1);
        else if (!rd_acc && readdatavalid) pend_d = pend_q - PW'(1);
        wr_cnt_d = wr_cnt_q + 16'(wr_acc);
        rd_cnt_d = rd_cnt_q + 16'(rd_acc);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            perr_q   <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            perr_q   <= perr_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Word RAM with per-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (byteenable[0]) mem[widx][7:0]  <= writedata[7:0];
            if (byteenable[1]) mem[widx][15:8] <= writedata[15:8];
        end
    end

    avmm_rd_pipe #(.STAGES(READ_LATENCY)) u_rd_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (rd_acc),
        .in_data  (mem[widx]),
        .out_vld  (readdatavalid),
        .out_data (readdata)
    );

    assign protocol_err = perr_q;
    assign toHexLed     = {wr_cnt_q, rd_cnt_q};

endmodule

// File: tb/tb_sdram_avmm_responder.sv
// Bench for sdram_avmm_responder: instance 0 uses 2 wait states / latency 3,
// instance 1 uses 0 wait states / latency 6 so the pending limit is reachable.
module tb_sdram_avmm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs [2], rdn [2], wrn [2];
    logic [1:0]  be [2];
    logic [31:0] addr [2];
    logic [15:0] wd [2];
    logic        wreq [2], rdv [2], perr [2];
    logic [15:0] rdata [2];
    logic [31:0] hex [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: word array, FIFO of expected returns, command counts.
    logic [15:0] mm [2][1024];
    logic [15:0] eq_d [2][32];
    int          eq_due [2][32];
    int          hd [2], n_out [2], mrd [2], mwr [2];
    int          mi, tl;
    bit          mc;

    sdram_avmm_responder #(.DEPTH(1024), .WAIT_STATES(2), .READ_LATENCY(3), .MAX_PENDING(4)) u_a (
        .clk(clk), .reset(reset), .chipselect(cs[0]), .read_n(rdn[0]), .write_n(wrn[0]),
        .byteenable(be[0]), .address(addr[0]), .writedata(wd[0]), .waitrequest(wreq[0]),
        .readdatavalid(rdv[0]), .readdata(rdata[0]), .protocol_err(perr[0]), .toHexLed(hex[0]));

    sdram_avmm_responder #(.DEPTH(1024), .WAIT_STATES(0), .READ_LATENCY(6), .MAX_PENDING(4)) u_b (
        .clk(clk), .reset(reset), .chipselect(cs[1]), .read_n(rdn[1]), .write_n(wrn[1]),
        .byteenable(be[1]), .address(addr[1]), .writedata(wd[1]), .waitrequest(wreq[1]),
        .readdatavalid(rdv[1]), .readdata(rdata[1]), .protocol_err(perr[1]), .toHexLed(hex[1]));

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic int lat(input int k);
        return (k == 0) ? 3 : 6;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model process: predicts every return from accepted commands.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                n_out[k] = 0; hd[k] = 0; mrd[k] = 0; mwr[k] = 0;
            end else begin
                mc = cs[k] && (rdn[k] != wrn[k]);
                if (k == 1 && mc) chk("b_wreq_full", 32'(wreq[1]), 32'(n_out[1] == 4));
                if (rdv[k]) begin
                    if (n_out[k] == 0) chk("rdv_unexpected", 32'(rdv[k]), 32'd0);
                    else begin
                        chk("rd_latency", cyc, eq_due[k][hd[k]]);
                        chk("rd_data", 32'(rdata[k]), 32'(eq_d[k][hd[k]]));
                        hd[k] = (hd[k] + 1) % 32;
                        n_out[k]--;
                    end
                end else if (n_out[k] > 0 && eq_due[k][hd[k]] == cyc) begin
                    chk("rdv_missing", 32'(rdv[k]), 32'd1);
                end
                if (mc && !wreq[k]) begin
                    mi = int'((addr[k] >> 1) % 1024);
                    if (!rdn[k]) begin
                        tl = (hd[k] + n_out[k]) % 32;
                        eq_d[k][tl]   = mm[k][mi];
                        eq_due[k][tl] = cyc + lat(k);
                        n_out[k]++;
                        mrd[k]++;
                    end else begin
                        if (be[k][0]) mm[k][mi][7:0]  = wd[k][7:0];
                        if (be[k][1]) mm[k][mi][15:8] = wd[k][15:8];
                        mwr[k]++;
                    end
                end
            end
        end
    end

    // Present one command (called just after a rising edge) and hold it until
    // accepted; returns just after the accepting edge.
    task automatic cmd(input int k, input bit rd, input logic [31:0] a, input logic [15:0] d,
                       input logic [1:0] b, output int waits);
        waits = 0;
        cs[k] = 1'b1; rdn[k] = ~rd; wrn[k] = rd; addr[k] = a; wd[k] = d; be[k] = b;
        forever begin
            @(negedge clk);
            if (!wreq[k]) break;
            waits++;
            if (waits > 100) begin
                chk("cmd_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        cs[k] = 1'b0; rdn[k] = 1'b1; wrn[k] = 1'b1;
    endtask

    task automatic read_chk(input int k, input logic [31:0] a, input logic [15:0] expd,
                            input int exp_waits, input string tag);
        int w, n;
        cmd(k, 1'b1, a, 16'h0, 2'b00, w);
        chk({tag, "_waits"}, 32'(w), 32'(exp_waits));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdv[k] && n < 20);
        chk({tag, "_lat"}, 32'(n), 32'(lat(k)));
        chk(tag, 32'(rdata[k]), 32'(expd));
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int w, seen, wb;
        logic [31:0] ra;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cs[k] = 1'b0; rdn[k] = 1'b1; wrn[k] = 1'b1; be[k] = 2'b00; addr[k] = '0; wd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_wreq", 32'(wreq[0]), 32'd0);
        chk("rst_rdv", 32'(rdv[0]), 32'd0);
        chk("rst_rdata", 32'(rdata[0]), 32'd0);
        chk("rst_perr", 32'(perr[0]), 32'd0);
        chk("rst_hex", hex[0], 32'd0);
        chk("rst_hex_b", hex[1], 32'd0);
        @(posedge clk); #1;

        // 1: write then read back with two wait states each
        cmd(0, 1'b0, 32'd10, 16'hBEEF, 2'b11, w);
        chk("t1_wr_waits", 32'(w), 32'd2);
        read_chk(0, 32'd10, 16'hBEEF, 2, "t1_rd");
        chk("t1_hex", hex[0], 32'h0001_0001);

        // 2: byte-lane merge
        cmd(0, 1'b0, 32'd20, 16'h1234, 2'b11, w);
        cmd(0, 1'b0, 32'd20, 16'hAB00, 2'b10, w);
        read_chk(0, 32'd20, 16'hAB34, 2, "t2_rd");

        // 6: address wraps on DEPTH
        read_chk(0, 32'd2058, 16'hBEEF, 2, "t6_wrap");

        // 5: read_n and write_n both low
        cs[0] = 1'b1; rdn[0] = 1'b0; wrn[0] = 1'b0; addr[0] = 32'd20; wd[0] = 16'hFFFF; be[0] = 2'b11;
        @(negedge clk);
        chk("t5_wreq", 32'(wreq[0]), 32'd0);
        @(posedge clk); #1;
        cs[0] = 1'b0; rdn[0] = 1'b1; wrn[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_perr", 32'(perr[0]), 32'd1);
        chk("t5_hex", hex[0], 32'h0003_0003);
        @(posedge clk); #1;
        read_chk(0, 32'd20, 16'hAB34, 2, "t5_ram");
        chk("t5_perr_sticky", 32'(perr[0]), 32'd1);

        // 4: reset with reads in flight
        cmd(0, 1'b1, 32'd10, 16'h0, 2'b00, w);
        cmd(0, 1'b1, 32'd20, 16'h0, 2'b00, w);
        pulse_reset();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdv[0]) seen++;
        end
        chk("t4_no_rdv", 32'(seen), 32'd0);
        chk("t4_hex", hex[0], 32'd0);
        chk("t4_perr", 32'(perr[0]), 32'd0);
        @(posedge clk); #1;
        read_chk(0, 32'd10, 16'hBEEF, 2, "t4_ram");
        chk("t4_hex_after", hex[0], 32'h0000_0001);

        // command withdrawn while stalled
        cs[0] = 1'b1; rdn[0] = 1'b0; wrn[0] = 1'b1; addr[0] = 32'd10;
        @(negedge clk);
        chk("wd_wreq", 32'(wreq[0]), 32'd1);
        @(posedge clk); #1;
        cs[0] = 1'b0; rdn[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("wd_perr", 32'(perr[0]), 32'd1);
        chk("wd_hex", hex[0], 32'h0000_0001);
        @(posedge clk); #1;
        pulse_reset();

        // 3: zero wait states, back-to-back reads up to the pending limit
        for (int i = 0; i < 64; i++) cmd(1, 1'b0, 32'(2 * i), 16'($urandom), 2'b11, w);
        cs[1] = 1'b1; rdn[1] = 1'b0; wrn[1] = 1'b1; addr[1] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            wb = 0;
            forever begin
                @(negedge clk);
                if (!wreq[1] || wb > 50) break;
                wb++;
            end
            if (i < 4) chk("t3_b2b_waits", 32'(wb), 32'd0);
            if (i == 4) chk("t3_full_waits", 32'(wb), 32'(lat(1) - 3));
            @(posedge clk); #1;
            addr[1] = 32'(2 * (i + 1));
        end
        cs[1] = 1'b0; rdn[1] = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // random traffic on both instances, checked by the model
        for (int i = 0; i < 64; i++) cmd(0, 1'b0, 32'(2 * i), 16'($urandom), 2'b11, w);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 150; i++) begin
                ra = ($urandom & 32'hFFFF_F800) | 32'(($urandom % 64) * 2) | 32'($urandom % 2);
                cmd(k, 1'($urandom % 2), ra, 16'($urandom), 2'($urandom % 4), w);
                if (k == 0) chk("rand_a_waits", 32'(w), 32'd2);
            end
            repeat (12) @(posedge clk);
            #1;
            chk("rand_drain", 32'(n_out[k]), 32'd0);
            chk("rand_hex", hex[k], {16'(mwr[k]), 16'(mrd[k])});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
